// File: rtl/cronometro_ctrl.sv
// ---------------------------------------------------------------------------
// cronometro_ctrl
//
// Control and sequencing core of an mm:ss stopwatch. A start/stop button and
// a clear button drive a four-state run/pause/clear FSM. A one-second
// prescaler advances a cascade of BCD digit counters (seconds units, seconds
// tens, minutes units, minutes tens). A free-running scan divider multiplexes
// the four digits onto a single 7-segment bus.
//
// Parameters
//   TICK_DIV  clock cycles per counted second (>= 2)
//   SCAN_DIV  clock cycles each digit stays selected (>= 1)
//
// Ports
//   CLK       system clock, every register updates on its rising edge
//   RST       synchronous active-high reset, overrides every other event
//   btn_ss    start/stop button level (debounced, CLK-synchronous)
//   btn_clr   clear button level (debounced, CLK-synchronous)
//   seg[6:0]  segments of the scanned digit, active-high, seg[6]=a..seg[0]=g
//   an[3:0]   one-hot digit enable, an[0]=seconds units..an[3]=minutes tens
//   d_su      seconds units digit (BCD)
//   d_st      seconds tens digit (BCD)
//   d_mu      minutes units digit (BCD)
//   d_mt      minutes tens digit (BCD)
//   run       high while counting
//   done      high once 59:59 has been reached and the count has stopped
//   sec_tick  registered one-cycle pulse for every counted second
// ---------------------------------------------------------------------------
module cronometro_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_ss,
    input  logic       btn_clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [3:0] d_su,
    output logic [3:0] d_st,
    output logic [3:0] d_mu,
    output logic [3:0] d_mt,
    output logic       run,
    output logic       done,
    output logic       sec_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   pre;
    logic [PW-1:0]   pre_nx;
    logic [SW-1:0]   scan_cnt;
    logic [1:0]      scan_idx;
    logic [3:0]      scan_digit;

    logic            btn_ss_q;
    logic            btn_clr_q;
    logic            ss_rise;
    logic            clr_rise;
    logic            tick;
    logic            clr_all;
    logic            at_max;

    logic [4:0]      su_inc;
    logic [4:0]      st_inc;
    logic [4:0]      mu_inc;
    logic [4:0]      mt_inc;

    // BCD increment with rollover at 'last'; bit 4 is the carry-out.
    function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic [3:0] last);
        if (d == last) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, d + 4'd1};
    endfunction

    // Active-high segment decode, a..g on bits 6..0. Non-BCD codes light
    // only the middle bar so a corrupted digit is visibly distinct.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h7E;
            4'd1:    return 7'h30;
            4'd2:    return 7'h6D;
            4'd3:    return 7'h79;
            4'd4:    return 7'h33;
            4'd5:    return 7'h5B;
            4'd6:    return 7'h5F;
            4'd7:    return 7'h70;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h7B;
            default: return 7'h01;
        endcase
    endfunction

    // Button edges act on the same clock edge that first samples the level high.
    assign ss_rise  = btn_ss  & ~btn_ss_q;
    assign clr_rise = btn_clr & ~btn_clr_q;

    assign at_max = (d_mt == 4'd5) && (d_mu == 4'd9) && (d_st == 4'd5) && (d_su == 4'd9);

    assign su_inc = bcd_inc(d_su, 4'd9);
    assign st_inc = bcd_inc(d_st, 4'd5);
    assign mu_inc = bcd_inc(d_mu, 4'd9);
    assign mt_inc = bcd_inc(d_mt, 4'd5);

    assign run  = (state == S_RUN);
    assign done = (state == S_DONE);

    // Next-state / prescaler logic. A stop request on the wrap cycle
    // suppresses that tick so the pause lands before the second is counted;
    // the prescaler then holds at its last value and the tick fires on the
    // first counting cycle after resume.
    always_comb begin
        state_nx = state;
        pre_nx   = pre;
        clr_all  = 1'b0;
        tick     = (state == S_RUN) && (pre == PRE_LAST) && !ss_rise;

        case (state)
            S_IDLE: begin
                // Start wins over a simultaneous clear; clear in IDLE is a no-op.
                if (ss_rise) begin
                    state_nx = S_RUN;
                    pre_nx   = '0;
                end
            end
            S_RUN: begin
                // Clear is ignored while counting.
                if (ss_rise) begin
                    state_nx = S_PAUSE;
                end else if (tick) begin
                    pre_nx = '0;
                    if (at_max) begin
                        state_nx = S_DONE;
                    end
                end else begin
                    pre_nx = pre + PW'(1);
                end
            end
            S_PAUSE: begin
                // Clear wins over a simultaneous start/stop.
                if (clr_rise) begin
                    state_nx = S_IDLE;
                    pre_nx   = '0;
                    clr_all  = 1'b1;
                end else if (ss_rise) begin
                    state_nx = S_RUN;
                end
            end
            S_DONE: begin
                if (clr_rise) begin
                    state_nx = S_IDLE;
                    pre_nx   = '0;
                    clr_all  = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                pre_nx   = '0;
                clr_all  = 1'b1;
            end
        endcase
    end

    // Control registers: FSM, prescaler, button history, tick strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            pre       <= '0;
            btn_ss_q  <= 1'b0;
            btn_clr_q <= 1'b0;
            sec_tick  <= 1'b0;
        end else begin
            state     <= state_nx;
            pre       <= pre_nx;
            btn_ss_q  <= btn_ss;
            btn_clr_q <= btn_clr;
            sec_tick  <= tick;
        end
    end

    // Digit cascade. The terminal tick at 59:59 leaves the digits untouched.
    always_ff @(posedge CLK) begin
        if (RST || clr_all) begin
            d_su <= 4'd0;
            d_st <= 4'd0;
            d_mu <= 4'd0;
            d_mt <= 4'd0;
        end else if (tick && !at_max) begin
            d_su <= su_inc[3:0];
            if (su_inc[4]) begin
                d_st <= st_inc[3:0];
                if (st_inc[4]) begin
                    d_mu <= mu_inc[3:0];
                    if (mu_inc[4]) begin
                        d_mt <= mt_inc[3:0];
                    end
                end
            end
        end
    end

    always_comb begin
        scan_digit = d_su;
        case (scan_idx)
            2'd0:    scan_digit = d_su;
            2'd1:    scan_digit = d_st;
            2'd2:    scan_digit = d_mu;
            2'd3:    scan_digit = d_mt;
            default: scan_digit = d_su;
        endcase
    end

    // Display scan: the index advances on each scan-divider wrap, and the
    // anode and segment registers sample the current index together so they
    // never show a mismatched digit/position pair.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
            an       <= 4'b0001;
            seg      <= 7'h7E;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= scan_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            an  <= 4'b0001 << scan_idx;
            seg <= seg_decode(scan_digit);
        end
    end

endmodule

// File: tb/tb_cronometro_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for cronometro_ctrl with TICK_DIV=4, SCAN_DIV=2.
// A directed vector table, hand-written corner sequences and a random phase
// are all compared every cycle against a reference model that tracks elapsed
// seconds as a plain integer and derives the mm:ss digits arithmetically.
// ---------------------------------------------------------------------------
module tb_cronometro_ctrl;

    localparam int TD = 4;
    localparam int SD = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_clr = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [3:0] d_su, d_st, d_mu, d_mt;
    logic       run, done, sec_tick;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int         m_mode;
    int         m_pre;
    int         m_secs;
    int         m_scan_n;
    logic       m_ss_q, m_clr_q;
    logic       m_tick;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    logic [6:0] dec_tab [10];

    typedef struct {
        logic        r;
        logic        ss;
        logic        clr;
        logic        e_run;
        logic        e_done;
        logic        e_tick;
        logic [15:0] e_dig;
    } vec_t;

    vec_t tbl [25];

    always #5 CLK = ~CLK;

    cronometro_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .CLK(CLK), .RST(RST), .btn_ss(btn_ss), .btn_clr(btn_clr),
        .seg(seg), .an(an), .d_su(d_su), .d_st(d_st), .d_mu(d_mu), .d_mt(d_mt),
        .run(run), .done(done), .sec_tick(sec_tick)
    );

    function automatic logic [15:0] bcd_of(input int s);
        int m;
        int ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int digit_at(input int s, input int idx);
        case (idx)
            0:       return s % 10;
            1:       return (s % 60) / 10;
            2:       return (s / 60) % 10;
            default: return s / 600;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge of the reference model, fed with the inputs present at the edge.
    task automatic model_edge(input logic r, input logic ss, input logic clr);
        logic ssr, cr;
        int   idx;
        if (r) begin
            m_mode = M_IDLE; m_pre = 0; m_secs = 0; m_scan_n = 0;
            m_ss_q = 1'b0; m_clr_q = 1'b0; m_tick = 1'b0;
            m_an = 4'b0001; m_seg = 7'h7E;
            return;
        end
        ssr = ss & ~m_ss_q;
        cr  = clr & ~m_clr_q;
        m_ss_q  = ss;
        m_clr_q = clr;
        idx   = (m_scan_n / SD) % 4;
        m_an  = 4'(1 << idx);
        m_seg = dec_tab[digit_at(m_secs, idx)];
        m_scan_n++;
        m_tick = 1'b0;
        case (m_mode)
            M_IDLE: if (ssr) begin m_mode = M_RUN; m_pre = 0; end
            M_RUN: begin
                if (ssr) m_mode = M_PAUSE;
                else if (m_pre == TD - 1) begin
                    m_tick = 1'b1;
                    m_pre  = 0;
                    if (m_secs == 3599) m_mode = M_DONE;
                    else m_secs++;
                end else m_pre++;
            end
            M_PAUSE: begin
                if (cr) begin m_mode = M_IDLE; m_secs = 0; m_pre = 0; end
                else if (ssr) m_mode = M_RUN;
            end
            default: if (cr) begin m_mode = M_IDLE; m_secs = 0; m_pre = 0; end
        endcase
    endtask

    function automatic logic [15:0] dut_dig();
        return {d_mt, d_mu, d_st, d_su};
    endfunction

    task automatic check_model();
        chk("model_run",  32'(run),       32'(m_mode == M_RUN));
        chk("model_done", 32'(done),      32'(m_mode == M_DONE));
        chk("model_tick", 32'(sec_tick),  32'(m_tick));
        chk("model_dig",  32'(dut_dig()), 32'(bcd_of(m_secs)));
        chk("model_an",   32'(an),        32'(m_an));
        chk("model_seg",  32'(seg),       32'(m_seg));
    endtask

    task automatic cyc(input logic r, input logic ss, input logic clr);
        RST = r; btn_ss = ss; btn_clr = clr;
        @(posedge CLK);
        model_edge(r, ss, clr);
        #1;
        check_model();
    endtask

    task automatic run_to(input int target, input int budget, input string name);
        for (int k = 0; k < budget && m_secs != target; k++) cyc(1'b0, 1'b0, 1'b0);
        chk(name, 32'(m_secs), 32'(target));
    endtask

    task automatic wait_pre(input int v, input string name);
        for (int k = 0; k < 10 && m_pre != v; k++) cyc(1'b0, 1'b0, 1'b0);
        chk(name, 32'(m_pre), 32'(v));
    endtask

    initial begin
        int cnt, last, frozen;
        int an_cnt [4];
        logic [6:0] exp_seg;

        dec_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

        //          r     ss    clr   run   done  tick  digits
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001};
        tbl[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[23] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

        model_edge(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            cyc(tbl[i].r, tbl[i].ss, tbl[i].clr);
            chk($sformatf("vec%0d_run", i),  32'(run),       32'(tbl[i].e_run));
            chk($sformatf("vec%0d_done", i), 32'(done),      32'(tbl[i].e_done));
            chk($sformatf("vec%0d_tick", i), 32'(sec_tick),  32'(tbl[i].e_tick));
            chk($sformatf("vec%0d_dig", i),  32'(dut_dig()), 32'(tbl[i].e_dig));
        end

        // reset state
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("rst_an",  32'(an),  32'h1);
        chk("rst_seg", 32'(seg), 32'h7E);
        chk("rst_dig", 32'(dut_dig()), 32'h0);

        // start pulse, 40 cycles -> ten ticks four cycles apart
        cyc(1'b0, 1'b1, 1'b0);
        chk("start_run", 32'(run), 32'h1);
        cnt = 0; last = -1;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (sec_tick) begin
                if (last >= 0) chk("tick_gap", 32'(i - last), 32'd4);
                last = i;
                cnt++;
            end
        end
        chk("tick_count", 32'(cnt), 32'd10);
        chk("dig_0010", 32'(dut_dig()), 32'h0010);

        // carry ripple
        run_to(59, 400, "reach_59");
        chk("dig_0059", 32'(dut_dig()), 32'h0059);
        run_to(60, 10, "reach_60");
        chk("dig_0100", 32'(dut_dig()), 32'h0100);
        chk("tick_0100", 32'(sec_tick), 32'h1);
        run_to(599, 3000, "reach_599");
        chk("dig_0959", 32'(dut_dig()), 32'h0959);
        run_to(600, 10, "reach_600");
        chk("dig_1000", 32'(dut_dig()), 32'h1000);

        // pause at prescaler 2, resume: tick two cycles after resume edge
        wait_pre(2, "pre2_found");
        frozen = m_secs;
        cyc(1'b0, 1'b1, 1'b0);
        chk("pause_run", 32'(run), 32'h0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("pause_frozen", 32'(dut_dig()), 32'(bcd_of(frozen)));
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk("resume_t0", 32'(sec_tick), 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("resume_t1", 32'(sec_tick), 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("resume_t2", 32'(sec_tick), 32'h1);
        chk("resume_dig", 32'(dut_dig()), 32'(bcd_of(frozen + 1)));

        // pause request on the wrap cycle suppresses the tick
        wait_pre(3, "pre3_found");
        frozen = m_secs;
        cyc(1'b0, 1'b1, 1'b0);
        chk("wrap_pause_tick", 32'(sec_tick), 32'h0);
        chk("wrap_pause_dig", 32'(dut_dig()), 32'(bcd_of(frozen)));
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("wrap_resume_t0", 32'(sec_tick), 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("wrap_resume_t1", 32'(sec_tick), 32'h1);

        // scan at 12:34
        run_to(754, 1000, "reach_1234");
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("dig_1234", 32'(dut_dig()), 32'h1234);
        for (int k = 0; k < 4; k++) an_cnt[k] = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            case (an)
                4'b0001: begin exp_seg = 7'h33; an_cnt[0]++; end
                4'b0010: begin exp_seg = 7'h79; an_cnt[1]++; end
                4'b0100: begin exp_seg = 7'h6D; an_cnt[2]++; end
                4'b1000: begin exp_seg = 7'h30; an_cnt[3]++; end
                default: exp_seg = 7'h00;
            endcase
            chk("scan_seg", 32'(seg), 32'(exp_seg));
        end
        for (int k = 0; k < 4; k++) chk($sformatf("scan_an%0d_held", k), 32'(an_cnt[k]), 32'd2);

        // run to the end
        cyc(1'b0, 1'b1, 1'b0);
        run_to(3599, 20000, "reach_5959");
        chk("dig_5959", 32'(dut_dig()), 32'h5959);
        for (int k = 0; k < 10 && m_mode != M_DONE; k++) cyc(1'b0, 1'b0, 1'b0);
        chk("end_done", 32'(done), 32'h1);
        chk("end_run",  32'(run),  32'h0);
        chk("end_tick", 32'(sec_tick), 32'h1);
        chk("end_dig",  32'(dut_dig()), 32'h5959);
        cyc(1'b0, 1'b0, 1'b0);
        chk("end_tick_off", 32'(sec_tick), 32'h0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("done_ss_ign", 32'(done), 32'h1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("done_hold_dig", 32'(dut_dig()), 32'h5959);
        cyc(1'b0, 1'b0, 1'b1);
        chk("done_clr", 32'(done), 32'h0);
        chk("done_clr_dig", 32'(dut_dig()), 32'h0000);

        // reset on the would-be tick edge
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        wait_pre(3, "pre3_rst");
        cyc(1'b1, 1'b0, 1'b0);
        chk("rst_mid_tick", 32'(sec_tick), 32'h0);
        chk("rst_mid_run",  32'(run), 32'h0);

        // random
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 299) == 0),
                1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
